// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM state encoding and port index.
package mem_arb_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } arb_state_t;

    typedef logic port_idx_t;

    localparam int NUM_PORTS = 2;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker: on a tie, the port not granted most recently wins.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_idx_t  last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a processor port and a loader/debug port onto one single-cycle data memory.
// state   | meaning
// IDLE    | arbitrate, issue the winning access to memory in the same cycle
// RD_WAIT | return captured read data (or an error) to the port that issued the read
module mem_arbiter #(
    parameter logic [31:0] DATA_START_ADDRESS = 32'h0080_0000,
    parameter int          DATA_ADDR_BITS     = 13,
    parameter bit          RR_ENABLE          = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        p1_err,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    import mem_arb_pkg::*;

    arb_state_t  state;
    port_idx_t   sel;
    port_idx_t   sel_q;
    port_idx_t   last_q;
    port_idx_t   rr_last;
    logic        last_vld_q;
    logic        run_q;
    logic        rd_ok_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_we;
    logic [1:0]  req;
    logic [1:0]  rr_gnt;
    logic [1:0]  fp_gnt;
    logic [1:0]  gnt;
    logic        issue;
    logic        in_range;
    logic        rd_active;

    assign req = {p1_req, p0_req};

    // Until the first grant, port 0 must win a tie, so present "port 1 was last".
    assign rr_last = last_vld_q ? last_q : 1'b1;

    rr_arb2 u_rr_arb2 (
        .req  (req),
        .last (rr_last),
        .gnt  (rr_gnt)
    );

    assign fp_gnt = p0_req ? 2'b01 : {p1_req, 1'b0};

    // run_q is cleared asynchronously, which keeps every grant low while in reset.
    assign gnt   = (run_q && state == IDLE) ? (RR_ENABLE ? rr_gnt : fp_gnt) : 2'b00;
    assign issue = |gnt;
    assign sel   = gnt[1];

    assign sel_we    = sel ? p1_we    : p0_we;
    assign sel_addr  = sel ? p1_addr  : p0_addr;
    assign sel_wdata = sel ? p1_wdata : p0_wdata;
    assign in_range  = (sel_addr[31:DATA_ADDR_BITS] == DATA_START_ADDRESS[31:DATA_ADDR_BITS]);

    assign mem_re    = issue && !sel_we && in_range;
    assign mem_we    = issue &&  sel_we && in_range;
    assign mem_addr  = issue ? sel_addr  : addr_q;
    assign mem_wdata = issue ? sel_wdata : wdata_q;

    assign rd_active = (state == RD_WAIT);
    assign p0_gnt    = gnt[0];
    assign p1_gnt    = gnt[1];
    assign p0_rvalid = rd_active && !sel_q;
    assign p1_rvalid = rd_active &&  sel_q;
    assign p0_rdata  = (p0_rvalid && rd_ok_q) ? mem_rdata : 32'h0;
    assign p1_rdata  = (p1_rvalid && rd_ok_q) ? mem_rdata : 32'h0;
    assign p0_err    = (p0_rvalid && !rd_ok_q) || (gnt[0] && sel_we && !in_range);
    assign p1_err    = (p1_rvalid && !rd_ok_q) || (gnt[1] && sel_we && !in_range);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            run_q      <= 1'b0;
            last_q     <= 1'b0;
            last_vld_q <= 1'b0;
            sel_q      <= 1'b0;
            rd_ok_q    <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
        end else begin
            run_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (issue) begin
                        last_q     <= sel;
                        last_vld_q <= 1'b1;
                        sel_q      <= sel;
                        rd_ok_q    <= in_range;
                        addr_q     <= sel_addr;
                        wdata_q    <= sel_wdata;
                        if (!sel_we) begin
                            state <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: round-robin and fixed-priority instances share stimulus and are
// checked every cycle against a transaction-level model plus directed literal checks.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [31:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;

    logic        a_p0_gnt, a_p0_rvalid, a_p0_err, a_p1_gnt, a_p1_rvalid, a_p1_err;
    logic [31:0] a_p0_rdata, a_p1_rdata, a_mem_addr, a_mem_wdata;
    logic        a_mem_re, a_mem_we;
    logic [31:0] a_mem_rdata = '0;
    logic        b_p0_gnt, b_p0_rvalid, b_p0_err, b_p1_gnt, b_p1_rvalid, b_p1_err;
    logic [31:0] b_p0_rdata, b_p1_rdata, b_mem_addr, b_mem_wdata;
    logic        b_mem_re, b_mem_we;
    logic [31:0] b_mem_rdata = '0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.RR_ENABLE(1'b1)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(a_p0_gnt), .p0_rvalid(a_p0_rvalid), .p0_rdata(a_p0_rdata), .p0_err(a_p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(a_p1_gnt), .p1_rvalid(a_p1_rvalid), .p1_rdata(a_p1_rdata), .p1_err(a_p1_err),
        .mem_addr(a_mem_addr), .mem_re(a_mem_re), .mem_we(a_mem_we),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    mem_arbiter #(.RR_ENABLE(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(b_p0_gnt), .p0_rvalid(b_p0_rvalid), .p0_rdata(b_p0_rdata), .p0_err(b_p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(b_p1_gnt), .p1_rvalid(b_p1_rvalid), .p1_rdata(b_p1_rdata), .p1_err(b_p1_err),
        .mem_addr(b_mem_addr), .mem_re(b_mem_re), .mem_we(b_mem_we),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] base_val(input logic [31:0] a);
        return (a == 32'h0080_0004) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
    endfunction

    function automatic logic in_rng(input logic [31:0] a);
        return (a >> 13) == (32'h0080_0000 >> 13);
    endfunction

    // Memory behind each DUT: sample the request mid-cycle, present read data after the edge.
    logic [31:0] rmem [logic [32:0]];
    initial begin
        logic        a_pend, b_pend;
        logic [31:0] a_nxt, b_nxt;
        forever begin
            @(negedge clk);
            a_pend = 1'b0;
            b_pend = 1'b0;
            if (a_mem_we) rmem[{1'b0, a_mem_addr}] = a_mem_wdata;
            if (b_mem_we) rmem[{1'b1, b_mem_addr}] = b_mem_wdata;
            if (a_mem_re) begin
                a_pend = 1'b1;
                a_nxt = rmem.exists({1'b0, a_mem_addr}) ? rmem[{1'b0, a_mem_addr}] : base_val(a_mem_addr);
            end
            if (b_mem_re) begin
                b_pend = 1'b1;
                b_nxt = rmem.exists({1'b1, b_mem_addr}) ? rmem[{1'b1, b_mem_addr}] : base_val(b_mem_addr);
            end
            @(posedge clk);
            if (a_pend) a_mem_rdata = a_nxt;
            if (b_pend) b_mem_rdata = b_nxt;
        end
    end

    // Transaction-level model: one pending read per DUT, a tie-priority port, and a shadow memory.
    logic [31:0] mmem [logic [32:0]];
    initial begin
        logic        m_pend [2];
        int          m_pport [2];
        logic        m_pinr [2];
        logic [31:0] m_pdata [2];
        logic [31:0] m_addr [2];
        logic [31:0] m_wd [2];
        int          m_prio [2];
        for (int d = 0; d < 2; d++) begin
            m_pend[d] = 1'b0; m_pport[d] = 0; m_pinr[d] = 1'b0; m_pdata[d] = '0;
            m_addr[d] = '0; m_wd[d] = '0; m_prio[d] = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                logic [1:0]  o_gnt, o_rv, o_err, e_gnt, e_rv, e_err;
                logic [31:0] o_rd0, o_rd1, o_addr, o_wd, e_rd0, e_rd1, e_addr, e_wd, data;
                logic        o_re, o_we, e_re, e_we, wwe, inr;
                logic [31:0] waddr, wwd;
                int          win;
                if (d == 0) begin
                    o_gnt = {a_p1_gnt, a_p0_gnt}; o_rv = {a_p1_rvalid, a_p0_rvalid};
                    o_err = {a_p1_err, a_p0_err}; o_rd0 = a_p0_rdata; o_rd1 = a_p1_rdata;
                    o_addr = a_mem_addr; o_wd = a_mem_wdata; o_re = a_mem_re; o_we = a_mem_we;
                end else begin
                    o_gnt = {b_p1_gnt, b_p0_gnt}; o_rv = {b_p1_rvalid, b_p0_rvalid};
                    o_err = {b_p1_err, b_p0_err}; o_rd0 = b_p0_rdata; o_rd1 = b_p1_rdata;
                    o_addr = b_mem_addr; o_wd = b_mem_wdata; o_re = b_mem_re; o_we = b_mem_we;
                end
                e_gnt = '0; e_rv = '0; e_err = '0; e_rd0 = '0; e_rd1 = '0; e_re = 1'b0; e_we = 1'b0;
                if (!rst_n) begin
                    m_pend[d] = 1'b0; m_prio[d] = 0; m_addr[d] = '0; m_wd[d] = '0;
                end else if (m_pend[d]) begin
                    e_rv[m_pport[d]] = 1'b1;
                    e_err[m_pport[d]] = !m_pinr[d];
                    data = m_pinr[d] ? m_pdata[d] : 32'h0;
                    if (m_pport[d] == 0) e_rd0 = data; else e_rd1 = data;
                    m_pend[d] = 1'b0;
                end else if (p0_req || p1_req) begin
                    if (p0_req && p1_req) win = (d == 0) ? m_prio[d] : 0;
                    else                  win = p1_req ? 1 : 0;
                    wwe   = (win == 1) ? p1_we    : p0_we;
                    waddr = (win == 1) ? p1_addr  : p0_addr;
                    wwd   = (win == 1) ? p1_wdata : p0_wdata;
                    inr   = in_rng(waddr);
                    e_gnt[win] = 1'b1;
                    m_addr[d] = waddr; m_wd[d] = wwd; m_prio[d] = 1 - win;
                    if (wwe) begin
                        e_we = inr;
                        e_err[win] = !inr;
                        if (inr) mmem[{d == 1, waddr}] = wwd;
                    end else begin
                        e_re = inr;
                        m_pend[d] = 1'b1; m_pport[d] = win; m_pinr[d] = inr;
                        m_pdata[d] = mmem.exists({d == 1, waddr}) ? mmem[{d == 1, waddr}] : base_val(waddr);
                    end
                end
                e_addr = m_addr[d];
                e_wd = m_wd[d];
                chk($sformatf("d%0d_gnt", d), 32'(o_gnt), 32'(e_gnt));
                chk($sformatf("d%0d_rvalid", d), 32'(o_rv), 32'(e_rv));
                chk($sformatf("d%0d_err", d), 32'(o_err), 32'(e_err));
                chk($sformatf("d%0d_p0_rdata", d), o_rd0, e_rd0);
                chk($sformatf("d%0d_p1_rdata", d), o_rd1, e_rd1);
                chk($sformatf("d%0d_mem_re", d), 32'(o_re), 32'(e_re));
                chk($sformatf("d%0d_mem_we", d), 32'(o_we), 32'(e_we));
                chk($sformatf("d%0d_mem_addr", d), o_addr, e_addr);
                chk($sformatf("d%0d_mem_wdata", d), o_wd, e_wd);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, p0_addr, p0_wdata, 1'b0, 1'b0, p1_addr, p1_wdata);
    endtask

    initial begin
        logic [31:0] addr_tab [6];
        addr_tab = '{32'h0080_0000, 32'h0080_0004, 32'h0080_0008, 32'h0080_1FFC,
                     32'h0080_2000, 32'h0040_0000};
        #2 rst_n = 1'b0;
        drive(1'b1, 1'b0, 32'h0080_0000, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        chk("rst_gnt_with_req", 32'(a_p0_gnt), 32'h0);
        chk("rst_mem_re", 32'(a_mem_re), 32'h0);
        chk("rst_mem_addr", a_mem_addr, 32'h0);

        // Release just after a falling edge so a rising edge precedes the next sample.
        #1 rst_n = 1'b1;
        drive(1'b1, 1'b1, 32'h0080_0020, 32'h11, 1'b1, 1'b1, 32'h0080_0024, 32'h22);
        for (int c = 0; c < 4; c++) begin
            logic [1:0] exp_g;
            exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge clk);
            chk($sformatf("rr_contend_gnt%0d", c), 32'({a_p1_gnt, a_p0_gnt}), 32'(exp_g));
            chk($sformatf("rr_contend_we%0d", c), 32'(a_mem_we), 32'h1);
            chk($sformatf("fp_contend_gnt%0d", c), 32'({b_p1_gnt, b_p0_gnt}), 32'h1);
            step();
        end
        p0_req = 1'b0;
        @(negedge clk);
        chk("fp_p1_after_p0_drop", 32'({b_p1_gnt, b_p0_gnt}), 32'h2);
        step(); idle(); step();

        drive(1'b1, 1'b0, 32'h0080_0004, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("rd_gnt", 32'(a_p0_gnt), 32'h1);
        chk("rd_mem_re", 32'(a_mem_re), 32'h1);
        step(); idle();
        @(negedge clk);
        chk("rd_rvalid", 32'(a_p0_rvalid), 32'h1);
        chk("rd_rdata", a_p0_rdata, 32'hDEAD_BEEF);
        chk("rd_err", 32'(a_p0_err), 32'h0);
        chk("rd_no_gnt_in_wait", 32'(a_p0_gnt), 32'h0);
        step();

        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0040_0000, 32'h0);
        @(negedge clk);
        chk("oor_gnt", 32'(a_p1_gnt), 32'h1);
        chk("oor_mem_re", 32'(a_mem_re), 32'h0);
        step(); idle();
        @(negedge clk);
        chk("oor_rvalid", 32'(a_p1_rvalid), 32'h1);
        chk("oor_rdata", a_p1_rdata, 32'h0);
        chk("oor_err", 32'(a_p1_err), 32'h1);
        step();

        drive(1'b1, 1'b1, 32'h0080_0010, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("raw_mem_we", 32'(a_mem_we), 32'h1);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0080_0010, 32'h0);
        step(); idle();
        @(negedge clk);
        chk("raw_rvalid", 32'(a_p1_rvalid), 32'h1);
        chk("raw_rdata", a_p1_rdata, 32'h1234_5678);
        step();

        drive(1'b1, 1'b1, 32'h0080_1FFC, 32'hAA, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("top_in_range_we", 32'(a_mem_we), 32'h1);
        chk("top_in_range_err", 32'(a_p0_err), 32'h0);
        step();
        drive(1'b1, 1'b1, 32'h0080_2000, 32'hBB, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("past_top_gnt", 32'(a_p0_gnt), 32'h1);
        chk("past_top_we", 32'(a_mem_we), 32'h0);
        chk("past_top_err", 32'(a_p0_err), 32'h1);
        step(); idle(); step();

        drive(1'b1, 1'b0, 32'h0080_0008, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(); idle();
        #1 chk("pre_reset_rvalid", 32'(a_p0_rvalid), 32'h1);
        #1 rst_n = 1'b0;
        #1 chk("reset_kills_rvalid", 32'(a_p0_rvalid), 32'h0);
        chk("reset_kills_rdata", a_p0_rdata, 32'h0);
        chk("reset_mem_addr", a_mem_addr, 32'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("no_rvalid_after_reset", 32'({a_p1_rvalid, a_p0_rvalid}), 32'h0);
        step();

        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  addr_tab[$urandom_range(0, 5)], $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  addr_tab[$urandom_range(0, 5)], $urandom);
            step();
        end
        idle();
        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_START_ADDRESS, default 32'h00800000, base address of the data memory region.
REQ-002 Parameter DATA_ADDR_BITS, default 13, number of byte-address bits decoded by the memory; the upper bits [31:DATA_ADDR_BITS] select the region.
REQ-003 Parameter RR_ENABLE, default 1; 1 selects round-robin arbitration, 0 selects fixed priority with port 0 highest.
REQ-004 Ports clk (in, 1, clock) and rst_n (in, 1, reset); one clock domain; reset is asynchronous and active-low.
REQ-005 Ports pN_req (in, 1, request), pN_we (in, 1, 1=write), pN_addr (in, 32, byte address) and pN_wdata (in, 32, write data), for N=0 (processor) and N=1 (loader/debug).
REQ-006 Ports pN_gnt (out, 1, request accepted), pN_rvalid (out, 1, read data valid), pN_rdata (out, 32, read data) and pN_err (out, 1, out-of-range access), for N=0 and N=1.
REQ-007 Ports mem_addr (out, 32), mem_re (out, 1), mem_we (out, 1) and mem_wdata (out, 32) drive the memory; mem_rdata (in, 32) is valid one cycle after a mem_re cycle.

Function
REQ-008 The FSM has two states: IDLE (arbitrate and issue) and RD_WAIT (capture read data).
REQ-009 In IDLE with at least one pN_req high, the arbiter selects exactly one port, asserts its pN_gnt for one cycle and drives its addr/wdata onto mem_* in the same cycle (combinational issue).
REQ-010 Round-robin rule: when both ports request, grant the port not granted most recently; after reset, port 0 has priority.
REQ-011 Fixed-priority rule (RR_ENABLE=0): port 0 always wins a simultaneous request.
REQ-012 In-range write: mem_we=1 in the grant cycle; the FSM stays in IDLE; no rvalid is produced.
REQ-013 In-range read: mem_re=1 in the grant cycle; the FSM moves to RD_WAIT.
REQ-014 In RD_WAIT: pN_rvalid=1 and pN_rdata=mem_rdata for the granted port; no new grant is issued; the FSM returns to IDLE; read latency is grant+1 cycle.
REQ-015 An access is in range iff addr[31:DATA_ADDR_BITS]==DATA_START_ADDRESS[31:DATA_ADDR_BITS].
REQ-016 Out-of-range access: pN_gnt=1 and mem_re=mem_we=0. A read proceeds to RD_WAIT and returns rdata=0 with pN_err=1 alongside rvalid. A write asserts pN_err=1 in the grant cycle.
REQ-017 Maximum throughput is one write per cycle, or one read per two cycles.
REQ-018 mem_addr and mem_wdata hold their last issued value when idle; mem_re and mem_we are 0 whenever no grant is issued.
REQ-019 pN_rdata is 0 whenever pN_rvalid=0.
REQ-020 A requester holds req, we, addr and wdata stable until it sees gnt; it may drop req without penalty before gnt.
REQ-021 The arbiter never asserts both gnt outputs or both rvalid outputs in the same cycle.

Reset
REQ-022 rst_n low asynchronously forces: state IDLE, all gnt/rvalid/err=0, all rdata=0, mem_re=mem_we=0, mem_addr=mem_wdata=0, last-grant pointer reset to port 0.
REQ-023 Reset during RD_WAIT abandons the read; no rvalid follows after deassertion.
REQ-024 After rst_n deasserts, grants may be issued on the first rising clk edge.

Structure
REQ-025 A shared package mem_arb_pkg holds the FSM state enum (IDLE, RD_WAIT) and the port-index type.
REQ-026 The round-robin selection logic is one sub-module, rr_arb2 (inputs: req[1:0], last; output: one-hot grant).

Verification
REQ-027 Single read: p0 reads 0x00800004 with mem_rdata=0xDEADBEEF at cycle+1 -> p0_gnt at cycle T, p0_rvalid and p0_rdata=0xDEADBEEF at T+1, p0_err=0.
REQ-028 Contention: p0 and p1 hold continuous writes for 4 cycles after reset -> grants alternate p0,p1,p0,p1, with mem_we=1 every cycle.
REQ-029 Fixed priority: RR_ENABLE=0, both ports request continuously -> p0 granted every time and p1 starved until p0_req drops.
REQ-030 Out of range: p1 reads 0x00400000 -> p1_gnt, mem_re=0, p1_rvalid=1, p1_rdata=0 and p1_err=1 one cycle later.
REQ-031 Reset mid-read: rst_n pulsed low during RD_WAIT -> outputs zero immediately and no rvalid after release.
REQ-032 Read-after-write: p0 writes 0x12345678 to 0x00800010, then p1 reads the same address -> p1_rdata=0x12345678.
